// File: rtl/uart_core_if.sv
// Signal bundle between the bus-side logic and uart_core, plus the TX/RX line pins.
// Latency: none; this is wiring only.
// Backpressure: tx_start/tx_ready and rx_valid/rx_ack carry all flow control.
interface uart_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    // Bus side: issues transmit requests, drives the RX pin, consumes received words.
    modport master (
        output tx_start, tx_data, rx, rx_ack,
        input  tx_ready, tx_busy, tx, rx_data, rx_valid,
        input  rx_frame_err, rx_parity_err, rx_overrun
    );

    // Core side.
    modport slave (
        input  tx_start, tx_data, rx, rx_ack,
        output tx_ready, tx_busy, tx, rx_data, rx_valid,
        output rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART: 16x oversampled receiver, ready/start transmitter; parity via UART_CORE_PARITY_EN.
// Latency: tx start bit one cycle after accept; rx_valid one cycle after the stop-bit sample.
// Backpressure: tx_start ignored while busy; a word arriving while rx_valid is set is dropped and flagged as overrun.
module uart_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_core_if.slave bus
);
    localparam int DIV      = CLK_FREQ / (BAUD_RATE * 16);
    localparam int BIT_CLKS = 16 * DIV;
    localparam int TXC_W    = $clog2(STOP_BITS * BIT_CLKS + 1);
    localparam int TICK_W   = $clog2(DIV + 1);

    // Reject configurations the datapath cannot represent.
    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_core: CLK_FREQ too low for BAUD_RATE*16");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
            $error("uart_core: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_core: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
            $error("uart_core: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t            tx_state, tx_state_nx;
    logic [TXC_W-1:0]     tx_cnt, tx_cnt_nx;
    logic [3:0]           tx_idx, tx_idx_nx;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
    logic                 tx_par, tx_par_nx;
    logic                 tx_line, tx_line_nx;
    logic                 tx_rdy, tx_rdy_nx;
    logic                 tx_bsy;
    logic                 tx_bit_end;

    assign tx_bit_end = (tx_cnt == TXC_W'(BIT_CLKS - 1));

    // TX state and datapath registers; line forced idle-high by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
            tx_rdy   <= 1'b1;
            tx_bsy   <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_idx   <= tx_idx_nx;
            tx_shift <= tx_shift_nx;
            tx_par   <= tx_par_nx;
            tx_line  <= tx_line_nx;
            tx_rdy   <= tx_rdy_nx;
            tx_bsy   <= ~tx_rdy_nx;
        end
    end

    // TX next state: the line value for each bit is registered at the edge that starts it.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt + TXC_W'(1);
        tx_idx_nx   = tx_idx;
        tx_shift_nx = tx_shift;
        tx_par_nx   = tx_par;
        tx_line_nx  = tx_line;
        tx_rdy_nx   = tx_rdy;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nx = '0;
                if (bus.tx_start) begin
                    tx_state_nx = TX_START;
                    tx_shift_nx = bus.tx_data;
                    tx_par_nx   = (^bus.tx_data) ^ 1'(PARITY_ODD);
                    tx_line_nx  = 1'b0;
                    tx_rdy_nx   = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_nx = TX_DATA;
                    tx_cnt_nx   = '0;
                    tx_idx_nx   = '0;
                    tx_line_nx  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_nx = '0;
                    if (tx_idx == 4'(DATA_BITS - 1)) begin
`ifdef UART_CORE_PARITY_EN
                        tx_state_nx = TX_PARITY;
                        tx_line_nx  = tx_par;
`else
                        tx_state_nx = TX_STOP;
                        tx_line_nx  = 1'b1;
`endif
                    end else begin
                        tx_idx_nx   = tx_idx + 4'd1;
                        tx_shift_nx = tx_shift >> 1;
                        tx_line_nx  = tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_nx = TX_STOP;
                    tx_cnt_nx   = '0;
                    tx_line_nx  = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == TXC_W'(STOP_BITS * BIT_CLKS - 1)) begin
                    tx_state_nx = TX_IDLE;
                    tx_cnt_nx   = '0;
                    tx_rdy_nx   = 1'b1;
                end
            end
            default: begin
                tx_state_nx = TX_IDLE;
                tx_line_nx  = 1'b1;
                tx_rdy_nx   = 1'b1;
            end
        endcase
    end

    assign bus.tx       = tx_line;
    assign bus.tx_ready = tx_rdy;
    assign bus.tx_busy  = tx_bsy;

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic                 rx_meta, rx_sync;
    logic [TICK_W-1:0]    tick_cnt;
    logic                 tick;

    rx_state_t            rx_state, rx_state_nx;
    logic [3:0]           rx_tcnt, rx_tcnt_nx;
    logic [3:0]           rx_idx, rx_idx_nx;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_nx;
    logic                 rx_perr_w, rx_perr_w_nx;
    logic [DATA_BITS-1:0] rx_dat, rx_dat_nx;
    logic                 rx_vld, rx_vld_nx;
    logic                 rx_ferr, rx_ferr_nx;
    logic                 rx_perr, rx_perr_nx;
    logic                 rx_ovr, rx_ovr_nx;
    logic                 rx_done;

    assign tick = (tick_cnt == TICK_W'(DIV - 1));

    // Two-flop synchroniser (idles high) and free-running oversample tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            tick_cnt <= '0;
        end else begin
            rx_meta  <= bus.rx;
            rx_sync  <= rx_meta;
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    // RX state and delivered-word registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            rx_tcnt   <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            rx_perr_w <= 1'b0;
            rx_dat    <= '0;
            rx_vld    <= 1'b0;
            rx_ferr   <= 1'b0;
            rx_perr   <= 1'b0;
            rx_ovr    <= 1'b0;
        end else begin
            rx_state  <= rx_state_nx;
            rx_tcnt   <= rx_tcnt_nx;
            rx_idx    <= rx_idx_nx;
            rx_shift  <= rx_shift_nx;
            rx_perr_w <= rx_perr_w_nx;
            rx_dat    <= rx_dat_nx;
            rx_vld    <= rx_vld_nx;
            rx_ferr   <= rx_ferr_nx;
            rx_perr   <= rx_perr_nx;
            rx_ovr    <= rx_ovr_nx;
        end
    end

    // RX next state: half-bit check of the start edge, then one sample every 16 ticks.
    always_comb begin
        rx_state_nx  = rx_state;
        rx_tcnt_nx   = rx_tcnt;
        rx_idx_nx    = rx_idx;
        rx_shift_nx  = rx_shift;
        rx_perr_w_nx = rx_perr_w;
        rx_dat_nx    = rx_dat;
        rx_vld_nx    = rx_vld;
        rx_ferr_nx   = rx_ferr;
        rx_perr_nx   = rx_perr;
        rx_ovr_nx    = rx_ovr;
        rx_done      = 1'b0;
        if (tick) begin
            rx_tcnt_nx = rx_tcnt + 4'd1;
            case (rx_state)
                RX_IDLE: begin
                    rx_tcnt_nx = '0;
                    if (!rx_sync) begin
                        rx_state_nx  = RX_START;
                        rx_perr_w_nx = 1'b0;
                    end
                end
                RX_START: begin
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt_nx  = '0;
                        rx_idx_nx   = '0;
                        rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt_nx  = '0;
                        rx_shift_nx = {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == 4'(DATA_BITS - 1)) begin
`ifdef UART_CORE_PARITY_EN
                            rx_state_nx = RX_PARITY;
`else
                            rx_state_nx = RX_STOP;
`endif
                        end else begin
                            rx_idx_nx = rx_idx + 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt_nx   = '0;
                        rx_perr_w_nx = ((^rx_shift) ^ rx_sync) != 1'(PARITY_ODD);
                        rx_state_nx  = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt_nx  = '0;
                        rx_done     = 1'b1;
                        rx_state_nx = RX_IDLE;
                    end
                end
                default: rx_state_nx = RX_IDLE;
            endcase
        end
        // An ack in the completion cycle frees the slot, so the new word loads without overrun.
        if (rx_done) begin
            if (!rx_vld || bus.rx_ack) begin
                rx_dat_nx  = rx_shift;
                rx_vld_nx  = 1'b1;
                rx_ferr_nx = ~rx_sync;
                rx_perr_nx = rx_perr_w;
                rx_ovr_nx  = bus.rx_ack ? 1'b0 : rx_ovr;
            end else begin
                rx_ovr_nx = 1'b1;
            end
        end else if (bus.rx_ack) begin
            rx_vld_nx  = 1'b0;
            rx_ferr_nx = 1'b0;
            rx_perr_nx = 1'b0;
            rx_ovr_nx  = 1'b0;
        end
    end

    assign bus.rx_data       = rx_dat;
    assign bus.rx_valid      = rx_vld;
    assign bus.rx_frame_err  = rx_ferr;
    assign bus.rx_parity_err = rx_perr;
    assign bus.rx_overrun    = rx_ovr;
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: 8-bit/1-stop instance with switchable loopback, 5-bit/2-stop instance looped back.
// Expected TX line levels and RX words come from a scoreboard filled when stimulus is driven.
// Parity cases are compiled only when UART_CORE_PARITY_EN is defined.
module tb_uart_core;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT      = 160;
`ifdef UART_CORE_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic loop;
    logic rx_drv;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t       q0[$];
    logic [4:0] q1[$];

    always #5 clk = ~clk;

    uart_core_if #(.DATA_BITS(8)) if0();
    uart_core_if #(.DATA_BITS(5)) if1();

    assign if0.rx = loop ? if0.tx : rx_drv;
    assign if1.rx = if1.tx;

    uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send one word on dut0 and compare the line at each bit centre; optionally hold
    // tx_start high for the rest of the frame to show it is ignored while busy.
    task automatic tx_check(input logic [7:0] d, input bit poke);
        logic bits[$];
        int   n;
        int   cyc;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (P != 0) bits.push_back(^d);
        bits.push_back(1'b1);
        n = bits.size();
        @(negedge clk);
        if0.tx_start = 1'b1;
        if0.tx_data  = d;
        @(posedge clk); #1;
        if0.tx_start = 1'b0;
        check("tx_ready_fall", if0.tx_ready, 1'b0);
        check("tx_busy_rise", if0.tx_busy, 1'b1);
        check("tx_start_bit_now", if0.tx, 1'b0);
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            repeat ((k == 0) ? BIT / 2 : BIT) @(posedge clk);
            cyc += (k == 0) ? BIT / 2 : BIT;
            #1;
            check($sformatf("tx_bit%0d", k), if0.tx, bits.pop_front());
            if (poke && k == 3) begin
                if0.tx_start = 1'b1;
                if0.tx_data  = ~d;
            end
        end
        while (!if0.tx_ready && cyc < n * BIT + 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if0.tx_start = 1'b0;
        check("tx_frame_len", cyc, n * BIT);
        check("tx_busy_fall", if0.tx_busy, 1'b0);
    endtask

    // Drive a frame onto dut0's rx pin; a low stop bit is released early so the
    // trailing low does not look like a new start.
    task automatic drive_rx(input logic [7:0] d, input logic pbit, input logic stop);
        rx_drv = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BIT) @(posedge clk);
        end
        if (P != 0) begin
            rx_drv = pbit;
            repeat (BIT) @(posedge clk);
        end
        rx_drv = stop;
        repeat (100) @(posedge clk);
        rx_drv = 1'b1;
        repeat (60) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx0(input int bound);
        int   c;
        exp_t e;
        c = 0;
        while (!if0.rx_valid && c < bound) begin
            @(posedge clk); #1;
            c++;
        end
        check("rx_valid", if0.rx_valid, 1'b1);
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check("rx_data", if0.rx_data, e.data);
            check("rx_frame_err", if0.rx_frame_err, e.ferr);
            check("rx_parity_err", if0.rx_parity_err, e.perr);
        end
    endtask

    task automatic ack0();
        @(negedge clk);
        if0.rx_ack = 1'b1;
        @(posedge clk); #1;
        if0.rx_ack = 1'b0;
        check("ack_valid_clr", if0.rx_valid, 1'b0);
        check("ack_ferr_clr", if0.rx_frame_err, 1'b0);
        check("ack_perr_clr", if0.rx_parity_err, 1'b0);
        check("ack_ovr_clr", if0.rx_overrun, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n        = 1'b0;
        loop         = 1'b0;
        rx_drv       = 1'b1;
        if0.tx_start = 1'b0;
        if0.tx_data  = '0;
        if0.rx_ack   = 1'b0;
        if1.tx_start = 1'b0;
        if1.tx_data  = '0;
        if1.rx_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", if0.tx, 1'b1);
        check("rst_tx_ready", if0.tx_ready, 1'b1);
        check("rst_tx_busy", if0.tx_busy, 1'b0);
        check("rst_rx_data", if0.rx_data, 8'h00);
        check("rst_rx_valid", if0.rx_valid, 1'b0);
        check("rst_ferr", if0.rx_frame_err, 1'b0);
        check("rst_perr", if0.rx_parity_err, 1'b0);
        check("rst_ovr", if0.rx_overrun, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // TX frame, with tx_start held during the frame
        tx_check(8'hA5, 1'b1);
        repeat (5) @(posedge clk); #1;
        check("tx_start_not_queued", if0.tx_ready, 1'b1);
        check("no_rx_without_loop", if0.rx_valid, 1'b0);

        // Loopback
        loop = 1'b1;
        q0.push_back('{8'h3C, 1'b0, 1'b0});
        tx_check(8'h3C, 1'b0);
        wait_rx0(400);
        ack0();
        loop = 1'b0;
        repeat (200) @(posedge clk);

        // Framing error: word still delivered
        q0.push_back('{8'h5A, 1'b1, 1'b0});
        drive_rx(8'h5A, ^8'h5A, 1'b0);
        wait_rx0(400);
        ack0();
        repeat (200) @(posedge clk);

`ifdef UART_CORE_PARITY_EN
        loop = 1'b1;
        q0.push_back('{8'h07, 1'b0, 1'b0});
        tx_check(8'h07, 1'b0);
        wait_rx0(400);
        ack0();
        loop = 1'b0;
        repeat (200) @(posedge clk);
        q0.push_back('{8'h07, 1'b0, 1'b1});
        drive_rx(8'h07, 1'b0, 1'b1);
        wait_rx0(400);
        ack0();
        repeat (200) @(posedge clk);
`endif

        // Overrun: second word lost, first kept
        q0.push_back('{8'h11, 1'b0, 1'b0});
        drive_rx(8'h11, ^8'h11, 1'b1);
        drive_rx(8'h22, ^8'h22, 1'b1);
        repeat (20) @(posedge clk); #1;
        wait_rx0(10);
        check("rx_overrun", if0.rx_overrun, 1'b1);
        ack0();
        repeat (200) @(posedge clk);

        // False start
        rx_drv = 1'b0;
        repeat (40) @(posedge clk);
        rx_drv = 1'b1;
        repeat (2000) @(posedge clk); #1;
        check("false_start_valid", if0.rx_valid, 1'b0);
        check("false_start_ferr", if0.rx_frame_err, 1'b0);

        // Reset in the middle of a TX frame
        @(negedge clk);
        if0.tx_start = 1'b1;
        if0.tx_data  = 8'h00;
        @(posedge clk); #1;
        if0.tx_start = 1'b0;
        repeat (500) @(posedge clk); #1;
        check("mid_frame_tx_low", if0.tx, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_tx", if0.tx, 1'b1);
        check("rst_mid_tx_ready", if0.tx_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);

        // 5 data bits, 2 stop bits, looped back on dut1
        q1.push_back(5'h15);
        @(negedge clk);
        if1.tx_start = 1'b1;
        if1.tx_data  = 5'h15;
        @(posedge clk); #1;
        if1.tx_start = 1'b0;
        c = 0;
        while (!if1.tx_ready && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        check("tx5_frame_len", c, (1 + 5 + P + 2) * BIT);
        check("rx5_valid", if1.rx_valid, 1'b1);
        if (q1.size() != 0) check("rx5_data", if1.rx_data, q1.pop_front());
        check("rx5_ferr", if1.rx_frame_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
